// File: rtl/pgm_memory.sv
// -----------------------------------------------------------------------------
// pgm_memory
//
// Program memory that sits on a shared tri-state system bus. It has two modes.
//
// Run mode (IDLE):
//   - While enable=1 the word at 'address' is placed on w_bus with no clock
//     latency.
//   - With write_en=1 and enable=0, the word on w_bus is stored at the next
//     clock edge.
//
// Programming mode (LOAD/DONE):
//   - Entered while prog_mode is high. A loader streams words into
//     consecutive addresses starting at 0, using a valid/ready handshake.
//   - prog_done rises once the last address has been filled.
//
// Reset does not clear the memory contents.
//
// Optional build macro:
//   PGM_MEMORY_PARITY_EN - each word also stores an even-parity bit, and
//                          parity_err flags a mismatch on the word being read.
//
// Parameters:
//   DATA_W  word width in bits
//   ADDR_W  address width; depth = 2**ADDR_W words
//
// Ports:
//   clk, rst     clock (rising edge); asynchronous active-high reset
//   enable       drive mem[address] onto w_bus (run mode)
//   write_en     store w_bus into mem[address] at next edge (run mode)
//   address      run-mode word address
//   w_bus        shared bidirectional bus; high-Z when not driven
//   prog_mode    high selects programming mode
//   prog_valid   prog_data holds a word to load
//   prog_data    word to load
//   prog_ready   loader accepts a word this cycle
//   prog_addr    address the next loaded word goes to
//   prog_done    all words loaded
//   parity_err   parity mismatch on the word currently driven
// -----------------------------------------------------------------------------
module pgm_memory #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] w_bus,
  input  logic              prog_mode,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic [ADDR_W-1:0] prog_addr,
  output logic              prog_done,
  output logic              parity_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t state;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              bus_drive;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // The bus is only driven in run mode, and never while reset is held.
  // Gating on rst keeps the bus released even before the state register
  // settles.
  assign bus_drive = !rst && (state == IDLE) && enable;
  assign rd_data   = mem[address];
  assign w_bus     = bus_drive ? rd_data : {DATA_W{1'bz}};

  // A single write port is shared by the bus path and the loader path.
  // The two sources are mutually exclusive by state.
  // A read has priority over a bus write (enable=1 suppresses write_en),
  // because the memory itself is driving the bus in that case.
  // A load beat on the same edge that prog_mode drops is not taken, because
  // leaving programming mode wins.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = address;
    wr_data = w_bus;
    if (!rst) begin
      if ((state == IDLE) && write_en && !enable) begin
        wr_en = 1'b1;
      end else if ((state == LOAD) && prog_mode && prog_valid) begin
        wr_en   = 1'b1;
        wr_addr = prog_addr;
        wr_data = prog_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Mode sequencer.
  // prog_ready and prog_done are registered alongside the state, so they
  // change only on a clock edge or on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prog_addr  <= '0;
      prog_ready <= 1'b0;
      prog_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (prog_mode) begin
            state      <= LOAD;
            prog_addr  <= '0;
            prog_ready <= 1'b1;
            prog_done  <= 1'b0;
          end
        end
        LOAD: begin
          if (!prog_mode) begin
            state      <= IDLE;
            prog_ready <= 1'b0;
            prog_done  <= 1'b0;
          end else if (prog_valid) begin
            // Wraps naturally to 0 after the last word.
            prog_addr <= prog_addr + 1'b1;
            if (prog_addr == LAST_ADDR) begin
              state      <= DONE;
              prog_ready <= 1'b0;
              prog_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!prog_mode) begin
            state      <= IDLE;
            prog_ready <= 1'b0;
            prog_done  <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          prog_addr  <= '0;
          prog_ready <= 1'b0;
          prog_done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PGM_MEMORY_PARITY_EN
  logic par_mem [DEPTH];

  // The parity bit is computed from whatever word is written, whether it
  // arrives from the bus or from the loader.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      par_mem[wr_addr] <= ^wr_data;
    end
  end

  assign parity_err = bus_drive && ((^rd_data) != par_mem[address]);
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_pgm_memory.sv
// -----------------------------------------------------------------------------
// tb_pgm_memory
//
// Self-checking bench for pgm_memory (DATA_W=8, ADDR_W=4).
//
// A reference image of the memory (ref_mem) is updated by the bench from the
// visible transactions:
//   - bus writes
//   - accepted loader beats
//
// Every read is compared against that image. Loader behaviour is checked
// against a simple count of accepted beats.
// -----------------------------------------------------------------------------
module tb_pgm_memory;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          enable     = 1'b0;
  logic          write_en   = 1'b0;
  logic [AW-1:0] address    = '0;
  logic          prog_mode  = 1'b0;
  logic          prog_valid = 1'b0;
  logic [DW-1:0] prog_data  = '0;
  logic          tb_drv     = 1'b0;
  logic [DW-1:0] tb_data    = '0;
  wire  [DW-1:0] w_bus;
  logic          prog_ready;
  logic [AW-1:0] prog_addr;
  logic          prog_done;
  logic          parity_err;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] ref_mem [DEPTH];

  typedef struct {
    logic          en;
    logic          we;
    logic          drv;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          exp_z;
    logic [DW-1:0] exp;
  } vec_t;

  assign w_bus = tb_drv ? tb_data : {DW{1'bz}};

  always #5 clk = ~clk;

  pgm_memory #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .write_en   (write_en),
    .address    (address),
    .w_bus      (w_bus),
    .prog_mode  (prog_mode),
    .prog_valid (prog_valid),
    .prog_data  (prog_data),
    .prog_ready (prog_ready),
    .prog_addr  (prog_addr),
    .prog_done  (prog_done),
    .parity_err (parity_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkBus(input string name, input logic exp_z,
                          input logic [DW-1:0] exp);
    logic [DW-1:0] zval;
    zval = {DW{1'bz}};
    if (exp_z) checkOutput(name, {24'h0, w_bus}, {24'h0, zval});
    else       checkOutput(name, {24'h0, w_bus}, {24'h0, exp});
  endtask

  task automatic applyStimulus(input logic en, input logic we,
                               input logic [AW-1:0] a, input logic drv,
                               input logic [DW-1:0] d);
    enable   = en;
    write_en = we;
    address  = a;
    tb_drv   = drv;
    tb_data  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic readAll(input string name);
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b1, 1'b0, AW'(a), 1'b0, '0);
      #1;
      checkBus(name, 1'b0, ref_mem[a]);
      checkOutput("parity_read", {31'h0, parity_err}, 32'h0);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    vec_t vecs[8];
    int   n;
    int   loaded;
    int   guard;
    logic en;
    logic we;
    logic drv;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    // Reset state, with enable high to show the bus stays released.
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0);
    #2;
    checkOutput("rst_ready", {31'h0, prog_ready}, 32'h0);
    checkOutput("rst_addr",  {28'h0, prog_addr},  32'h0);
    checkOutput("rst_done",  {31'h0, prog_done},  32'h0);
    checkOutput("rst_parity", {31'h0, parity_err}, 32'h0);
    checkBus("rst_bus_z", 1'b1, '0);

    // Full bulk load of 0x10..0x1F, one stall in the middle.
    tick();
    rst       = 1'b0;
    prog_mode = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
    tick();
    checkOutput("load_entry_ready", {31'h0, prog_ready}, 32'h1);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 8) begin
        prog_valid = 1'b0;
        prog_data  = 8'hEE;
        tick();
        checkOutput("stall_addr", {28'h0, prog_addr}, 32'(i));
      end
      checkOutput("load_addr",  {28'h0, prog_addr},  32'(i));
      checkOutput("load_ready", {31'h0, prog_ready}, 32'h1);
      // Run-mode controls must be ignored while loading.
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, 15)), 1'b0, '0);
      prog_valid = 1'b1;
      prog_data  = DW'(8'h10 + i);
      #1;
      checkBus("load_bus_z", 1'b1, '0);
      tick();
      ref_mem[i] = DW'(8'h10 + i);
    end
    checkOutput("done_flag",  {31'h0, prog_done},  32'h1);
    checkOutput("done_ready", {31'h0, prog_ready}, 32'h0);
    checkOutput("done_wrap",  {28'h0, prog_addr},  32'h0);

    // Words offered in DONE are ignored.
    prog_data = 8'hEE;
    tick();
    checkOutput("done_hold", {31'h0, prog_done}, 32'h1);
    prog_valid = 1'b0;
    prog_mode  = 1'b0;
    tick();
    checkOutput("exit_done", {31'h0, prog_done}, 32'h0);

    // Run-mode table: read, release, bus write, read-priority-over-write.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 4'd7,  8'h00, 1'b0, 8'h17};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 4'd7,  8'h00, 1'b1, 8'h00};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 4'd3,  8'hA5, 1'b0, 8'hA5};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 4'd3,  8'h00, 1'b0, 8'hA5};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 4'd3,  8'h00, 1'b0, 8'hA5};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 4'd3,  8'h00, 1'b0, 8'hA5};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 8'h10};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 4'd15, 8'h00, 1'b0, 8'h1F};
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].en, vecs[v].we, vecs[v].addr, vecs[v].drv,
                    vecs[v].data);
      #1;
      checkBus($sformatf("vec%0d_bus", v), vecs[v].exp_z, vecs[v].exp);
      checkOutput("vec_parity", {31'h0, parity_err}, 32'h0);
      tick();
      if (vecs[v].we && !vecs[v].en) ref_mem[vecs[v].addr] = vecs[v].data;
    end

    // Random run-mode traffic against the reference image.
    for (int it = 0; it < 150; it++) begin
      en  = 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      a   = AW'($urandom_range(0, 15));
      d   = DW'($urandom);
      drv = we && !en;
      applyStimulus(en, we, a, drv, d);
      #1;
      if (en)       checkBus("rand_read", 1'b0, ref_mem[a]);
      else if (drv) checkBus("rand_drive", 1'b0, d);
      else          checkBus("rand_idle_z", 1'b1, '0);
      checkOutput("rand_parity", {31'h0, parity_err}, 32'h0);
      tick();
      if (drv) ref_mem[a] = d;
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);

    // Random partial (or full) loads with random stalls.
    for (int r = 0; r < 3; r++) begin
      n         = (r == 2) ? DEPTH : $urandom_range(1, 15);
      loaded    = 0;
      guard     = 0;
      prog_mode = 1'b1;
      tick();
      while (loaded < n && guard < 200) begin
        guard++;
        checkOutput("rload_addr", {28'h0, prog_addr}, 32'(loaded));
        prog_valid = 1'($urandom_range(0, 1));
        prog_data  = DW'($urandom);
        tick();
        if (prog_valid) begin
          ref_mem[loaded] = prog_data;
          loaded++;
        end
      end
      checkOutput("rload_budget", 32'(loaded), 32'(n));
      checkOutput("rload_done", {31'h0, prog_done},
                  (n == DEPTH) ? 32'h1 : 32'h0);
      prog_valid = 1'b0;
      prog_mode  = 1'b0;
      tick();
      readAll("rload_read");
    end

    // Reset in the middle of a load, then re-entry with prog_mode held.
    prog_mode = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      prog_valid = 1'b1;
      prog_data  = DW'(8'hC0 + i);
      tick();
      ref_mem[i] = DW'(8'hC0 + i);
    end
    prog_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_ready", {31'h0, prog_ready}, 32'h0);
    checkOutput("midrst_addr",  {28'h0, prog_addr},  32'h0);
    checkOutput("midrst_done",  {31'h0, prog_done},  32'h0);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("reentry_ready", {31'h0, prog_ready}, 32'h1);
    checkOutput("reentry_addr",  {28'h0, prog_addr},  32'h0);
    prog_mode = 1'b0;
    tick();
    readAll("midrst_read");

`ifdef PGM_MEMORY_PARITY_EN
    // Corrupt one stored bit without updating its parity bit.
    applyStimulus(1'b1, 1'b0, 4'd2, 1'b0, '0);
    #1;
    checkOutput("parity_clean", {31'h0, parity_err}, 32'h0);
    dut.mem[2] = dut.mem[2] ^ 8'h01;
    #1;
    checkOutput("parity_flip", {31'h0, parity_err}, 32'h1);
    dut.mem[2] = dut.mem[2] ^ 8'h01;
    #1;
    checkOutput("parity_restored", {31'h0, parity_err}, 32'h0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pgm_memory.md
PGM_MEMORY -- requirements
Module: pgm_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, address width; depth = 2**ADDR_W words.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port enable  input  1  drive addressed word onto w_bus.
REQ-006 SHALL have port write_en  input  1  store w_bus into addressed word at next clk edge.
REQ-007 SHALL have port address  input  ADDR_W  run-mode word address.
REQ-008 SHALL have port w_bus  inout  DATA_W  shared system bus; high-Z when not driving.
REQ-009 SHALL have port prog_mode  input  1  high selects programming (bulk load) mode.
REQ-010 SHALL have port prog_valid  input  1  prog_data holds a word to load.
REQ-011 SHALL have port prog_data  input  DATA_W  word to load.
REQ-012 SHALL have port prog_ready  output  1  loader accepts a word this cycle.
REQ-013 SHALL have port prog_addr  output  ADDR_W  address the next loaded word goes to.
REQ-014 SHALL have port prog_done  output  1  all words loaded.
REQ-015 SHALL have port parity_err  output  1  parity mismatch on current read.

Function
REQ-016 SHALL implement FSM states IDLE (run), LOAD, DONE.
REQ-017 IDLE: w_bus = mem[address] combinationally while enable=1, else high-Z; no clock latency on read.
REQ-018 IDLE: write_en=1 and enable=0 at clk edge SHALL write w_bus to mem[address].
REQ-019 IDLE: enable=1 and write_en=1 together SHALL perform the read only; write suppressed (no bus contention).
REQ-020 IDLE -> LOAD when prog_mode=1 at clk edge; prog_addr set to 0 on entry.
REQ-021 LOAD: prog_ready=1; each edge with prog_valid=1 writes prog_data to mem[prog_addr] and increments prog_addr.
REQ-022 LOAD: prog_valid=0 SHALL stall with no write and prog_addr held.
REQ-023 LOAD: accepting the word at address 2**ADDR_W-1 SHALL move to DONE; prog_addr wraps to 0.
REQ-024 DONE: prog_done=1, prog_ready=0, further prog_valid ignored.
REQ-025 LOAD or DONE: w_bus high-Z and write_en/enable ignored regardless of their values.
REQ-026 prog_mode=0 at a clk edge in LOAD or DONE SHALL return to IDLE; prog_done cleared; contents kept.
REQ-027 Leaving LOAD early SHALL keep words already loaded; remaining words unchanged.
REQ-028 parity_err SHALL be 0 whenever w_bus is not driven.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, prog_addr=0, prog_ready=0, prog_done=0, parity_err=0, w_bus high-Z.
REQ-030 Reset SHALL NOT clear memory contents; reset during LOAD aborts with loaded words preserved.
REQ-031 After rst deasserts with prog_mode=1, FSM SHALL re-enter LOAD at the next edge, starting at address 0.

Configuration
REQ-032 Macro PGM_MEMORY_PARITY_EN defined: each word stores an extra even-parity bit computed on every write (bus or loader).
REQ-033 With PGM_MEMORY_PARITY_EN: parity_err=1 combinationally while IDLE, enable=1 and stored parity mismatches the word read.
REQ-034 Without PGM_MEMORY_PARITY_EN: no parity storage; parity_err tied to 0; all other behaviour identical.

Verification
REQ-035 Reset, prog_mode=1, drive 16 words 0x10..0x1F with prog_valid=1 -> prog_addr 0..15, prog_done=1 after 16th edge, prog_ready=0.
REQ-036 Loaded image, prog_mode=0, address=7, enable=1 -> w_bus=0x17 same cycle; enable=0 -> w_bus=Z.
REQ-037 IDLE, address=3, bench drives 0xA5, write_en=1, enable=0, one edge; then enable=1 -> w_bus=0xA5.
REQ-038 enable=1 and write_en=1 at address=3 -> w_bus shows old 0xA5, no write occurs.
REQ-039 Assert rst after 5 loaded words, mid-LOAD -> prog_ready=0, prog_addr=0 immediately; words 0-4 readable, words 5-15 unchanged.
REQ-040 PARITY_EN build: force-flip a stored bit at address 2, enable=1 -> parity_err=1; clean word -> parity_err=0.
